hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 6-stage pipeline (F, D, E, M1, M, W). It complements the bypass network.
- Detects hazards that forwarding cannot resolve: load-use, multi-cycle mul/div in E, and instruction/data memory wait states. Also handles taken-branch redirects resolved in E.
- Drives per-stage pipeline-register hold (stall) and bubble-insert (flush) controls, and keeps a stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the F/D/E/M1/M/W pipeline.
// Ports: D-stage sources, E/M1 writeback info, mul/div and memory
// busy inputs in; per-stage stall_*/flush_*, mc_busy/mc_done and a
// stall-cycle counter out.
module hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_ra1,
  input  logic [4:0]       d_ra2,
  input  logic             d_use1,
  input  logic             d_use2,
  input  logic             e_wr_en,
  input  logic             m1_wr_en,
  input  logic [4:0]       e_wr_reg,
  input  logic [4:0]       m1_wr_reg,
  input  logic             e_memr,
  input  logic             m1_memr,
  input  logic             e_mc,
  input  logic             e_is_div,
  input  logic             e_br_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m1,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m1,
  output logic             flush_w,
  output logic             mc_busy,
  output logic             mc_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MAXL = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW   = (MAXL > 2) ? $clog2(MAXL) : 1;
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT - 2);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_stall_cycles;

  logic [CW-1:0] w_load;
  logic          w_match_e;
  logic          w_match_m1;
  logic          w_mem;
  logic          w_mc;
  logic          w_lu;
  logic          w_if;
  logic          w_br;
  logic          w_sf;
  logic          w_sd;
  logic          w_se;
  logic          w_sm;

  assign w_load = e_is_div ? DIV_LD : MUL_LD;

  assign w_match_e =
    (d_use1 & (d_ra1 == e_wr_reg)) |
    (d_use2 & (d_ra2 == e_wr_reg));
  assign w_match_m1 =
    (d_use1 & (d_ra1 == m1_wr_reg)) |
    (d_use2 & (d_ra2 == m1_wr_reg));

  assign w_mem = dmem_busy;
  assign w_mc  = ((r_state == S_IDLE) & e_mc) |
                 (r_state == S_RUN);
  assign w_lu  =
    (e_memr & e_wr_en & (e_wr_reg != 5'd0) & w_match_e) |
    (m1_memr & m1_wr_en & (m1_wr_reg != 5'd0) & w_match_m1);
  assign w_if  = imem_busy;

  assign w_sm = w_mem;
  assign w_se = w_mem | w_mc;
  // A taken branch only counts once E is free to move.
  assign w_br = e_br_taken & ~w_se;
  // Redirect must load into F/D, so it beats LU/IF holds there.
  assign w_sd = (w_se | w_lu) & ~w_br;
  assign w_sf = (w_se | w_lu | w_if) & ~w_br;

  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m1 = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b1;
    flush_e  = 1'b1;
    flush_m1 = 1'b1;
    flush_w  = 1'b1;
    mc_busy  = 1'b0;
    mc_done  = 1'b0;
    if (!reset) begin
      stall_f  = w_sf;
      stall_d  = w_sd;
      stall_e  = w_se;
      stall_m1 = w_sm;
      stall_m  = w_sm;
      flush_w  = w_mem;
      flush_m1 = w_mc & ~w_sm;
      flush_e  = (w_lu | w_br) & ~w_se;
      flush_d  = (w_if | w_br) & ~w_sd;
      mc_busy  = (r_state == S_RUN);
      mc_done  = (r_state == S_DONE);
    end
  end

  // Counter runs regardless of dmem_busy; result waits in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (e_mc) begin
            r_cnt   <= w_load;
            r_state <= (w_load == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!dmem_busy) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_sf) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl.
// Drives per-cycle vectors and checks stall/flush/FSM outputs.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_ra1, d_ra2;
  logic        d_use1, d_use2;
  logic        e_wr_en, m1_wr_en;
  logic [4:0]  e_wr_reg, m1_wr_reg;
  logic        e_memr, m1_memr;
  logic        e_mc, e_is_div, e_br_taken;
  logic        imem_busy, dmem_busy;
  logic        stall_f, stall_d, stall_e, stall_m1, stall_m;
  logic        flush_d, flush_e, flush_m1, flush_w;
  logic        mc_busy, mc_done;
  logic [31:0] stall_cycles;

  logic [4:0]  st;
  logic [3:0]  fl;
  int          n_chk = 0;
  int          n_pass = 0;
  int          exp_cnt = 0;

  assign st = {stall_f, stall_d, stall_e, stall_m1, stall_m};
  assign fl = {flush_d, flush_e, flush_m1, flush_w};

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .d_ra1(d_ra1), .d_ra2(d_ra2),
    .d_use1(d_use1), .d_use2(d_use2),
    .e_wr_en(e_wr_en), .m1_wr_en(m1_wr_en),
    .e_wr_reg(e_wr_reg), .m1_wr_reg(m1_wr_reg),
    .e_memr(e_memr), .m1_memr(m1_memr),
    .e_mc(e_mc), .e_is_div(e_is_div),
    .e_br_taken(e_br_taken),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m1(stall_m1),
    .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e),
    .flush_m1(flush_m1), .flush_w(flush_w),
    .mc_busy(mc_busy), .mc_done(mc_done),
    .stall_cycles(stall_cycles)
  );

  task automatic clr();
    d_ra1 = 0; d_ra2 = 0; d_use1 = 0; d_use2 = 0;
    e_wr_en = 0; m1_wr_en = 0;
    e_wr_reg = 0; m1_wr_reg = 0;
    e_memr = 0; m1_memr = 0;
    e_mc = 0; e_is_div = 0; e_br_taken = 0;
    imem_busy = 0; dmem_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr();
    reset = 1; imem_busy = 1; dmem_busy = 1; e_mc = 1;
    #1;
    n_chk++;
    if (st !== 5'b00000)
      $display("FAIL rst_stall got=%b exp=00000", st);
    else n_pass++;
    n_chk++;
    if (fl !== 4'b1111)
      $display("FAIL rst_flush got=%b exp=1111", fl);
    else n_pass++;
    n_chk++;
    if ({mc_busy, mc_done} !== 2'b00)
      $display("FAIL rst_mc got=%b exp=00", {mc_busy, mc_done});
    else n_pass++;
    tick();
    n_chk++;
    if (stall_cycles !== 32'd0)
      $display("FAIL rst_cnt got=%0d exp=0", stall_cycles);
    else n_pass++;
    reset = 0;
    clr();
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_load_use();
    clr();
    d_ra1 = 5; d_use1 = 1;
    e_memr = 1; e_wr_en = 1; e_wr_reg = 5;
    #1;
    n_chk++;
    if ({st, fl} !== {5'b11000, 4'b0100})
      $display("FAIL lu_e got=%b_%b exp=11000_0100", st, fl);
    else n_pass++;
    tick();
    e_memr = 0; e_wr_en = 0; e_wr_reg = 0;
    m1_memr = 1; m1_wr_en = 1; m1_wr_reg = 5;
    #1;
    n_chk++;
    if ({st, fl} !== {5'b11000, 4'b0100})
      $display("FAIL lu_m1 got=%b_%b exp=11000_0100", st, fl);
    else n_pass++;
    tick();
    m1_memr = 0; m1_wr_en = 0; m1_wr_reg = 0;
    #1;
    n_chk++;
    if ({st, fl} !== 9'b0)
      $display("FAIL lu_clear got=%b_%b exp=00000_0000", st, fl);
    else n_pass++;
    exp_cnt += 2;
    n_chk++;
    if (stall_cycles !== 32'(exp_cnt))
      $display("FAIL lu_cnt got=%0d exp=%0d", stall_cycles, exp_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_lu_filter();
    clr();
    e_memr = 1; e_wr_en = 1; e_wr_reg = 0;
    d_ra1 = 0; d_use1 = 1;
    #1;
    n_chk++;
    if ({st, fl} !== 9'b0)
      $display("FAIL lu_x0 got=%b_%b exp=00000_0000", st, fl);
    else n_pass++;
    tick();
    e_wr_reg = 9; d_ra1 = 9; d_use1 = 0;
    #1;
    n_chk++;
    if ({st, fl} !== 9'b0)
      $display("FAIL lu_unused got=%b_%b exp=00000_0000", st, fl);
    else n_pass++;
    tick();
    clr();
    m1_memr = 1; m1_wr_en = 1; m1_wr_reg = 12;
    d_ra2 = 12; d_use2 = 1;
    #1;
    n_chk++;
    if ({st, fl} !== {5'b11000, 4'b0100})
      $display("FAIL lu_ra2 got=%b_%b exp=11000_0100", st, fl);
    else n_pass++;
    exp_cnt += 1;
    tick();
    m1_wr_en = 0;
    #1;
    n_chk++;
    if ({st, fl} !== 9'b0)
      $display("FAIL lu_nowr got=%b_%b exp=00000_0000", st, fl);
    else n_pass++;
    tick();
    clr();
  endtask

  task automatic test_mul();
    logic [4:0] es;
    logic [3:0] ef;
    logic [1:0] em;
    clr();
    e_mc = 1; e_is_div = 0;
    for (int i = 0; i < 3; i++) begin
      es = (i < 2) ? 5'b11100 : 5'b00000;
      ef = (i < 2) ? 4'b0010 : 4'b0000;
      em = (i == 1) ? 2'b10 : (i == 2) ? 2'b01 : 2'b00;
      #1;
      n_chk++;
      if ({st, fl, mc_busy, mc_done} !== {es, ef, em})
        $display("FAIL mul_c%0d got=%b_%b_%b exp=%b_%b_%b",
                 i, st, fl, {mc_busy, mc_done}, es, ef, em);
      else n_pass++;
      tick();
    end
    exp_cnt += 2;
    e_mc = 0;
    #1;
    n_chk++;
    if ({st, mc_busy, mc_done} !== 7'b0)
      $display("FAIL mul_after got=%b_%b exp=0", st, {mc_busy, mc_done});
    else n_pass++;
    tick();
  endtask

  task automatic test_div();
    logic [4:0] es;
    logic [1:0] em;
    clr();
    e_mc = 1; e_is_div = 1;
    for (int i = 0; i < 16; i++) begin
      es = (i < 15) ? 5'b11100 : 5'b00000;
      em = (i >= 1 && i <= 14) ? 2'b10 :
           (i == 15) ? 2'b01 : 2'b00;
      #1;
      n_chk++;
      if ({st, mc_busy, mc_done} !== {es, em})
        $display("FAIL div_c%0d got=%b_%b exp=%b_%b",
                 i, st, {mc_busy, mc_done}, es, em);
      else n_pass++;
      tick();
    end
    exp_cnt += 15;
    e_mc = 0;
    #1;
    n_chk++;
    if (stall_cycles !== 32'(exp_cnt))
      $display("FAIL div_cnt got=%0d exp=%0d", stall_cycles, exp_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_mem_run();
    logic       dm;
    logic [4:0] es;
    logic [3:0] ef;
    logic [1:0] em;
    clr();
    e_mc = 1; e_is_div = 1;
    for (int i = 0; i < 19; i++) begin
      dm = (i >= 3 && i <= 5) || (i >= 15 && i <= 17);
      dmem_busy = dm;
      es = dm ? 5'b11111 : (i <= 14) ? 5'b11100 : 5'b00000;
      ef = dm ? 4'b0001 : (i <= 14) ? 4'b0010 : 4'b0000;
      em = (i >= 1 && i <= 14) ? 2'b10 :
           (i >= 15) ? 2'b01 : 2'b00;
      #1;
      n_chk++;
      if ({st, fl, mc_busy, mc_done} !== {es, ef, em})
        $display("FAIL memrun_c%0d got=%b_%b_%b exp=%b_%b_%b",
                 i, st, fl, {mc_busy, mc_done}, es, ef, em);
      else n_pass++;
      tick();
    end
    exp_cnt += 18;
    clr();
    #1;
    n_chk++;
    if ({st, mc_busy, mc_done} !== 7'b0)
      $display("FAIL memrun_idle got=%b_%b exp=0", st, {mc_busy, mc_done});
    else n_pass++;
    n_chk++;
    if (stall_cycles !== 32'(exp_cnt))
      $display("FAIL memrun_cnt got=%0d exp=%0d", stall_cycles, exp_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_branch();
    clr();
    imem_busy = 1;
    #1;
    n_chk++;
    if ({st, fl} !== {5'b10000, 4'b1000})
      $display("FAIL if_only got=%b_%b exp=10000_1000", st, fl);
    else n_pass++;
    tick();
    e_memr = 1; e_wr_en = 1; e_wr_reg = 7;
    d_ra1 = 7; d_use1 = 1;
    #1;
    n_chk++;
    if ({st, fl} !== {5'b11000, 4'b0100})
      $display("FAIL if_lu got=%b_%b exp=11000_0100", st, fl);
    else n_pass++;
    tick();
    e_br_taken = 1;
    #1;
    n_chk++;
    if ({st, fl} !== {5'b00000, 4'b1100})
      $display("FAIL br_if_lu got=%b_%b exp=00000_1100", st, fl);
    else n_pass++;
    tick();
    imem_busy = 0; dmem_busy = 1;
    #1;
    n_chk++;
    if ({st, fl} !== {5'b11111, 4'b0001})
      $display("FAIL br_mem got=%b_%b exp=11111_0001", st, fl);
    else n_pass++;
    tick();
    exp_cnt += 3;
    clr();
    e_br_taken = 1;
    #1;
    n_chk++;
    if ({st, fl} !== {5'b00000, 4'b1100})
      $display("FAIL br_plain got=%b_%b exp=00000_1100", st, fl);
    else n_pass++;
    n_chk++;
    if (stall_cycles !== 32'(exp_cnt))
      $display("FAIL br_cnt got=%0d exp=%0d", stall_cycles, exp_cnt);
    else n_pass++;
    tick();
    clr();
  endtask

  task automatic test_reset_mid_run();
    clr();
    e_mc = 1; e_is_div = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_chk++;
      if (st !== 5'b11100)
        $display("FAIL midrst_c%0d got=%b exp=11100", i, st);
      else n_pass++;
      tick();
    end
    exp_cnt += 8;
    reset = 1;
    #1;
    n_chk++;
    if ({st, fl, mc_busy, mc_done} !== {5'b0, 4'b1111, 2'b00})
      $display("FAIL midrst_in got=%b_%b_%b exp=00000_1111_00",
               st, fl, {mc_busy, mc_done});
    else n_pass++;
    n_chk++;
    if (stall_cycles !== 32'(exp_cnt))
      $display("FAIL midrst_pre got=%0d exp=%0d", stall_cycles, exp_cnt);
    else n_pass++;
    tick();
    reset = 0;
    e_mc = 0;
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++;
      if ({st, mc_busy, mc_done} !== 7'b0 || stall_cycles !== 32'd0)
        $display("FAIL midrst_post%0d got=%b_%b_%0d exp=0_0_0",
                 i, st, {mc_busy, mc_done}, stall_cycles);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    clr();
    reset = 1;
    tick();
    tick();
    test_reset();
    test_load_use();
    test_lu_filter();
    test_mul();
    test_div();
    test_mem_run();
    test_branch();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
